// File: rtl/sd_cmd_if.sv
// Handshake/bus bundle between the host register file and the SD CMD serializer.
interface sd_cmd_if #(
    parameter int ARG_WIDTH = 32,
    parameter int IDX_WIDTH = 6
);
    logic [ARG_WIDTH-1:0] CommandArgument;
    logic [IDX_WIDTH-1:0] CommandIndex;
    logic                 cmd_start;
    logic                 bit_en;
    logic                 cmd_out;
    logic                 cmd_oe;
    logic                 busy;
    logic                 done;
    logic [6:0]           crc_out;

    modport master (
        output CommandArgument, CommandIndex, cmd_start, bit_en,
        input  cmd_out, cmd_oe, busy, done, crc_out
    );

    modport slave (
        input  CommandArgument, CommandIndex, cmd_start, bit_en,
        output cmd_out, cmd_oe, busy, done, crc_out
    );
endinterface

// File: rtl/sd_cmd_serializer.sv
// Serializes a 48-bit SD command token (start, tx, index, argument, CRC7, end)
// onto the CMD line, one bit per bit_en strobe.
module sd_cmd_serializer #(
    parameter int ARG_WIDTH = 32,
    parameter int IDX_WIDTH = 6,
    localparam int FRAME_LEN = 48
) (
    input  logic     clk,
    input  logic     rst,
    sd_cmd_if.slave  bus
);
    localparam int SHIFT_LEN = 2 + IDX_WIDTH + ARG_WIDTH;
    localparam logic [5:0] LAST_DATA = 6'(SHIFT_LEN - 1);
    localparam logic [5:0] LAST_CRC  = 6'(FRAME_LEN - 2);
    localparam logic [5:0] LAST_BIT  = 6'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t                 state, state_nx;
    logic [SHIFT_LEN-1:0]   shift_q;
    logic [6:0]             crc_q;
    logic [6:0]             crc_out_q;
    logic [5:0]             bit_cnt;
    logic [6:0]             crc_next;

    assign crc_next = {crc_q[5:0], 1'b0} ^ ((shift_q[SHIFT_LEN-1] ^ crc_q[6]) ? 7'h09 : 7'h00);
    assign bus.crc_out = crc_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        bus.cmd_out = 1'b1;
        bus.cmd_oe  = 1'b0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        case (state)
            IDLE: if (bus.cmd_start) state_nx = SEND;
            SEND: begin
                bus.cmd_oe = 1'b1;
                bus.busy   = 1'b1;
                if (bit_cnt <= LAST_DATA)     bus.cmd_out = shift_q[SHIFT_LEN-1];
                else if (bit_cnt <= LAST_CRC) bus.cmd_out = crc_q[6];
                if (bus.bit_en && bit_cnt == LAST_BIT) state_nx = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // During the CRC phase crc_q is shifted so its MSB is always the bit on the line;
    // the frozen value has already been captured in crc_out_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q   <= '0;
            crc_q     <= '0;
            crc_out_q <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.cmd_start) begin
                    shift_q <= {1'b0, 1'b1, bus.CommandIndex, bus.CommandArgument};
                    crc_q   <= '0;
                    bit_cnt <= '0;
                end
                SEND: if (bus.bit_en) begin
                    if (bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 6'd1;
                    if (bit_cnt <= LAST_DATA) begin
                        shift_q <= {shift_q[SHIFT_LEN-2:0], 1'b0};
                        crc_q   <= crc_next;
                        if (bit_cnt == LAST_DATA) crc_out_q <= crc_next;
                    end else if (bit_cnt <= LAST_CRC) begin
                        crc_q <= {crc_q[5:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
